apb_master: RTL and testbench

// - APB initiator bridging the CPU data-memory port to APB responders (RAM, GPIO, ...).
// - Accepts single-cycle CPU requests and runs the APB IDLE->SETUP->ACCESS sequence.
// - Decodes the address to one PSEL line and returns PRDATA/completion to the CPU.
// - Sits between the multi-cycle CPU core and the APB slave fabric.

---
 rtl/apb_master.sv | 175 +++++++++++++++++
 tb/tb_apb_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB initiator that bridges the CPU data-memory port to the APB responder
// fabric. A one-cycle CPU request is latched and run through the
// IDLE -> SETUP -> ACCESS sequence. The address decodes to one PSEL lane, and
// read data and completion go back to the CPU as registered one-cycle pulses.
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   : the ACCESS wait is bounded by TIMEOUT_CYCLES. On expiry the
//               transfer ends with ready=1, err=1 and rdata=0.
//   undefined : ACCESS waits until the selected responder raises PREADY.
//
// Ports
//   PCLK     in   system/APB clock, rising edge
//   PRESET   in   asynchronous reset, active-low
//   req      in   CPU request strobe (sampled only while idle)
//   we       in   1=write, 0=read
//   addr     in   byte address
//   wdata    in   write data
//   rdata    out  read data, valid while ready=1
//   ready    out  one-cycle completion pulse
//   err      out  one-cycle error pulse, coincident with ready
//   PADDR    out  latched address
//   PWRITE   out  latched direction
//   PWDATA   out  latched write data
//   PENABLE  out  high during ACCESS
//   PSEL     out  one-hot responder select, index = addr[15:12]
//   PRDATA   in   responder i read data at [32*i +: 32]
//   PREADY   in   responder i ready
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req,
    input  logic                         we,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata,
    output logic                         ready,
    output logic                         err,
    output logic [31:0]                  PADDR,
    output logic                         PWRITE,
    output logic [31:0]                  PWDATA,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [32*NUM_SLAVES-1:0]     PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state;
    logic [3:0]            req_idx;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  addr_hit;
    logic [31:0]           sel_rdata;
    logic                  sel_ready;

`ifdef APB_TIMEOUT_EN
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT_CYCLES - 1);
    logic [4:0] wait_cnt;
`endif

    assign req_idx = addr[15:12];

    // One-hot decode of the lane index. An index beyond NUM_SLAVES leaves the
    // vector empty, so an empty vector also means "out of range".
    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(req_idx) == i) begin
                dec_sel[i] = 1'b1;
            end
        end
    end

    assign addr_hit = (addr[31:16] == BASE_ADDR[31:16]) && (dec_sel != '0);

    // Lane mux driven by the registered PSEL. Because PSEL is one-hot, this
    // looks only at the selected responder and ignores the others.
    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) begin
                sel_rdata = PRDATA[32*i +: 32];
                sel_ready = PREADY[i];
            end
        end
    end

    // Transfer sequencer. Every CPU-facing and bus-facing output is a flop.
    // ready/err default low each cycle so they come out as single pulses.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state   <= ST_IDLE;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        PADDR  <= addr;
                        PWRITE <= we;
                        PWDATA <= wdata;
                        if (addr_hit) begin
                            PSEL  <= dec_sel;
                            state <= ST_SETUP;
                        end else begin
                            // A decode miss never touches the bus.
                            ready <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    // PREADY is deliberately not sampled here.
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    // A responder answer in the same cycle as the timeout wins.
                    if (sel_ready) begin
                        if (!PWRITE) begin
                            rdata <= sel_rdata;
                        end
                        ready   <= 1'b1;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= ST_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        ready   <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
`else
                    // Without the timeout, a silent responder stalls here.
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Bench for apb_master with four responder lanes:
//   lane 0 : zero-wait,       PRDATA = 5A5A_0000
//   lane 1 : registered-PREADY RAM, 16 words
//   lane 2 : bench-controlled PREADY (stall_rdy), PRDATA = A5A5_0002
//   lane 3 : zero-wait,       PRDATA = 3333_3333
// ---------------------------------------------------------------------------
module tb_apb_master;

    logic         PCLK;
    logic         PRESET;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    logic         stall_rdy;
    logic         ram_rdy;
    logic [31:0]  ram [16];

    int total;
    int bad;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [3:0]  psel;
        int          pen;
    } vec_t;

    vec_t vecs [11];

    apb_master #(
        .NUM_SLAVES    (4),
        .BASE_ADDR     (32'h1000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ready  (ready),
        .err    (err),
        .PADDR  (PADDR),
        .PWRITE (PWRITE),
        .PWDATA (PWDATA),
        .PENABLE(PENABLE),
        .PSEL   (PSEL),
        .PRDATA (PRDATA),
        .PREADY (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // The RAM responder raises PREADY one cycle after it sees PSEL&&PENABLE.
    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            ram_rdy <= 1'b0;
        end else begin
            ram_rdy <= PSEL[1] && PENABLE && !ram_rdy;
            if (PSEL[1] && PENABLE && ram_rdy && PWRITE) begin
                ram[PADDR[5:2]] <= PWDATA;
            end
        end
    end

    assign PRDATA = {32'h3333_3333, 32'hA5A5_0002, ram[PADDR[5:2]], 32'h5A5A_0000};
    assign PREADY = {1'b1, stall_rdy, ram_rdy, 1'b1};

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance until ready rises, giving up after 40 cycles. The request must
    // already have been sampled by one edge when this is called, so n starts at 1.
    task automatic waitReady(output int n);
        n = 1;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Run one table vector: issue the request, measure latency, and check
    // the completion, the bus activity seen along the way, and the pulse drop.
    task automatic applyStimulus(input int idx, input vec_t v);
        int         n;
        int         pen;
        logic [3:0] psel_seen;
        req   = 1'b1;
        we    = v.we;
        addr  = v.addr;
        wdata = v.wdata;
        tick();
        req = 1'b0;
        we  = 1'b0;
        n = 1;
        psel_seen = PSEL;
        pen = int'(PENABLE);
        while (!ready && n < 40) begin
            tick();
            n++;
            psel_seen |= PSEL;
            pen += int'(PENABLE);
        end
        checkOutput($sformatf("v%0d latency", idx), 32'(n), 32'(v.lat));
        checkOutput($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.err});
        checkOutput($sformatf("v%0d rdata", idx), rdata, v.rdata);
        checkOutput($sformatf("v%0d psel_seen", idx), {28'd0, psel_seen}, {28'd0, v.psel});
        checkOutput($sformatf("v%0d penable_cycles", idx), 32'(pen), 32'(v.pen));
        checkOutput($sformatf("v%0d PADDR", idx), PADDR, v.addr);
        checkOutput($sformatf("v%0d PWRITE", idx), {31'd0, PWRITE}, {31'd0, v.we});
        checkOutput($sformatf("v%0d PWDATA", idx), PWDATA, v.wdata);
        tick();
        checkOutput($sformatf("v%0d ready_pulse", idx), {31'd0, ready}, 32'd0);
        checkOutput($sformatf("v%0d psel_after", idx), {28'd0, PSEL}, 32'd0);
        checkOutput($sformatf("v%0d penable_after", idx), {31'd0, PENABLE}, 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        total     = 0;
        bad       = 0;
        PRESET    = 1'b0;
        req       = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        stall_rdy = 1'b0;
        foreach (ram[i]) ram[i] = '0;

        //           we    addr           wdata          err   rdata          lat psel     pen
        vecs[0]  = '{1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 4, 4'b0010, 2};
        vecs[1]  = '{1'b0, 32'h1000_1004, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 4, 4'b0010, 2};
        vecs[2]  = '{1'b0, 32'h2000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 4'b0000, 0};
        vecs[3]  = '{1'b0, 32'h1000_5000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 4'b0000, 0};
        vecs[4]  = '{1'b1, 32'h1000_1008, 32'h1234_5678, 1'b0, 32'h0000_0000, 4, 4'b0010, 2};
        vecs[5]  = '{1'b0, 32'h1000_3000, 32'h0000_0000, 1'b0, 32'h3333_3333, 3, 4'b1000, 1};
        vecs[6]  = '{1'b1, 32'h1000_0000, 32'hCAFE_F00D, 1'b0, 32'h3333_3333, 3, 4'b0001, 1};
        vecs[7]  = '{1'b0, 32'h1000_1008, 32'h0000_0000, 1'b0, 32'h1234_5678, 4, 4'b0010, 2};
        vecs[8]  = '{1'b0, 32'h1000_1004, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 4, 4'b0010, 2};
        vecs[9]  = '{1'b0, 32'h1001_1004, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 4'b0000, 0};
        vecs[10] = '{1'b0, 32'h1000_0010, 32'h0000_0000, 1'b0, 32'h5A5A_0000, 3, 4'b0001, 1};

        // Reset state
        tick();
        tick();
        checkOutput("reset rdata", rdata, 32'd0);
        checkOutput("reset ready", {31'd0, ready}, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset PADDR", PADDR, 32'd0);
        checkOutput("reset PWRITE", {31'd0, PWRITE}, 32'd0);
        checkOutput("reset PWDATA", PWDATA, 32'd0);
        checkOutput("reset PSEL", {28'd0, PSEL}, 32'd0);
        checkOutput("reset PENABLE", {31'd0, PENABLE}, 32'd0);
        PRESET = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Back-to-back: the next request is issued in the same cycle as ready.
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h1000_0000;
        wdata = 32'h0000_0001;
        tick();
        req = 1'b0;
        waitReady(n);
        checkOutput("b2b first latency", 32'(n), 32'd3);
        checkOutput("b2b idle psel", {28'd0, PSEL}, 32'd0);
        req   = 1'b1;
        addr  = 32'h1000_0004;
        wdata = 32'h0000_0002;
        tick();
        req = 1'b0;
        checkOutput("b2b psel back", {28'd0, PSEL}, 32'd1);
        checkOutput("b2b ready low", {31'd0, ready}, 32'd0);
        waitReady(n);
        checkOutput("b2b second latency", 32'(n), 32'd3);
        checkOutput("b2b second PADDR", PADDR, 32'h1000_0004);
        tick();

        // Spurious PREADY during SETUP, then a second req during ACCESS.
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h1000_2000;
        tick();
        req = 1'b0;
        stall_rdy = 1'b1;
        tick();
        stall_rdy = 1'b0;
        checkOutput("setup spurious ready", {31'd0, ready}, 32'd0);
        checkOutput("access penable", {31'd0, PENABLE}, 32'd1);
        req  = 1'b1;
        we   = 1'b1;
        addr = 32'h1000_3000;
        tick();
        req = 1'b0;
        we  = 1'b0;
        checkOutput("ignored req PADDR", PADDR, 32'h1000_2000);
        checkOutput("ignored req PSEL", {28'd0, PSEL}, 32'd4);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(ready);
        end
        checkOutput("stall no ready", 32'(pulses), 32'd0);
        stall_rdy = 1'b1;
        tick();
        stall_rdy = 1'b0;
        checkOutput("stall release ready", {31'd0, ready}, 32'd1);
        checkOutput("stall release rdata", rdata, 32'hA5A5_0002);
        checkOutput("stall release err", {31'd0, err}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(ready);
        end
        checkOutput("single ready only", 32'(pulses), 32'd0);
        checkOutput("ignored req PADDR end", PADDR, 32'h1000_2000);

        // Reset during ACCESS drops the bus without a clock edge.
        req  = 1'b1;
        addr = 32'h1000_2000;
        tick();
        req = 1'b0;
        tick();
        checkOutput("pre-reset penable", {31'd0, PENABLE}, 32'd1);
        #2;
        PRESET = 1'b0;
        #1;
        checkOutput("async reset PSEL", {28'd0, PSEL}, 32'd0);
        checkOutput("async reset PENABLE", {31'd0, PENABLE}, 32'd0);
        tick();
        PRESET = 1'b1;
        stall_rdy = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(ready);
        end
        stall_rdy = 1'b0;
        checkOutput("no ready after reset", 32'(pulses), 32'd0);

        // Responder that never answers.
        req  = 1'b1;
        addr = 32'h1000_2000;
        tick();
        req = 1'b0;
`ifdef APB_TIMEOUT_EN
        waitReady(n);
        checkOutput("timeout latency", 32'(n), 32'd18);
        checkOutput("timeout err", {31'd0, err}, 32'd1);
        checkOutput("timeout rdata", rdata, 32'd0);
        tick();
        checkOutput("timeout psel", {28'd0, PSEL}, 32'd0);
`else
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            pulses += int'(ready);
        end
        checkOutput("wait forever", 32'(pulses), 32'd0);
        checkOutput("wait forever penable", {31'd0, PENABLE}, 32'd1);
        stall_rdy = 1'b1;
        tick();
        stall_rdy = 1'b0;
        checkOutput("late ready", {31'd0, ready}, 32'd1);
        checkOutput("late err", {31'd0, err}, 32'd0);
        checkOutput("late rdata", rdata, 32'hA5A5_0002);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
